out_channel_fifo: RTL and testbench
===================================

// Module: out_channel_fifo
// PURPOSE
//  Downstream consumer of the Zero VM "out" instruction. Buffers each word the core
//  writes to its output channel and serialises it to the host bench via valid/ready.
//  Tracks accepted-word count and overflow, then signals done once the core has
//  finished and the buffer has fully drained. Sits between the fpga core's outMem
//  write and the host/success checker.
// PARAMETERS
//  WIDTH   12   data width; equals MemoryElementWidth
//  DEPTH    4   FIFO entries; power of two, >= 2
//  TOTALW  16   width of the accepted-word counter
// PORTS
//  clock        in   1                   single clock, all logic on posedge
//  reset        in   1                   synchronous, active-high
//  in_valid     in   1                   core executed "out" this cycle
//  in_data      in   WIDTH               word written by "out"
//  vm_finished  in   1                   core reached default/finished; level or pulse
//  out_valid    out  1                   head word available to host
//  out_data     out  WIDTH               head word (oldest)
//  out_ready    in   1                   host accepts head when out_valid&&out_ready
//  count        out  $clog2(DEPTH+1)     words currently buffered
//  overflow     out  1                   sticky: a push met a full FIFO with no pop
//  total        out  TOTALW              words accepted since reset, saturating
//  done         out  1                   finished and drained; sticky until reset
// BEHAVIOUR
//  - Reset (sync, high): pointers=0, count=0, out_valid=0, out_data=0, overflow=0,
//    total=0, done=0, state=RUN. Reset mid-stream discards all buffered words.
//  - Circular buffer, head/tail pointers wrap modulo DEPTH. All outputs registered
//    or driven from registers.
//  - Latency: word pushed in cycle N is visible on out_valid/out_data in cycle N+1
//    (if FIFO was empty). Pop at cycle N advances head; next word shown in N+1.
//  - out_valid==(count!=0). out_data stable while out_valid&&!out_ready.
//  - Push+pop same cycle, any fill level incl. full: both occur, count unchanged,
//    no overflow.
//  - Push when full, no pop: overflow<=1 (see CONFIGURATION for data handling).
//  - Pop when empty: ignored. total increments on every accepted push; holds at
//    2^TOTALW-1.
//  - FSM:
//    RUN   : accepts in_valid. On vm_finished -> DRAIN; push in that same cycle
//            is still accepted.
//    DRAIN : in_valid ignored (not counted, no overflow). count==0 -> DONE.
//    DONE  : done=1, in_valid ignored, stays until reset.
//  - vm_finished with FIFO already empty: RUN->DRAIN, then DONE next cycle
//    (done at N+2).
//  - vm_finished while in DRAIN/DONE: no effect.
// CONFIGURATION
//  OUT_CHANNEL_WRAP_EN defined: push into full FIFO overwrites oldest entry.
//    Head and tail both advance, count stays DEPTH, overflow<=1. Mirrors the
//    core's outMemPos % NOut wrap.
//  Undefined (default): push into full FIFO is dropped. Contents unchanged,
//    total not incremented, overflow<=1.
// TESTING
//  1 Single word: push 2, out_ready=1. Next cycle out_valid=1, out_data=2; pop;
//    count=0, total=1.
//  2 Finish/drain: push 10,20,30, ready=0, then vm_finished. Raise ready: pops
//    10,20,30 in order. done=1 the cycle after count reaches 0; later in_valid
//    ignored.
//  3 Full boundary (DEPTH=4, ready=0): push 1..5.
//    Default: holds 1..4, overflow=1, total=4.
//    WRAP_EN: holds 2..5, overflow=1, total=5.
//  4 Full + simultaneous: fill 1..4, then push 9 with ready=1. Pops 1, count
//    stays 4, overflow=0. Drain gives 2,3,4,9.
//  5 Reset mid-stream: 3 words buffered, overflow=1. Assert reset one cycle:
//    count=0, out_valid=0, overflow=0, total=0, done=0, state RUN.
//  6 Immediate finish: vm_finished with empty FIFO. done=1 two cycles later;
//    out_valid never rises.

Source files
------------

// File: rtl/out_channel_fifo.sv
// Output-channel FIFO for the Zero VM "out" instruction: buffers core writes and
// hands them to the host over valid/ready. Optional wrap mode: `OUT_CHANNEL_WRAP_EN.
module out_channel_fifo #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 4,
  parameter int TOTALW = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         vm_finished,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [TOTALW-1:0]            total,
  output logic                         done
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0]   FULL_CNT  = CNTW'(DEPTH);
  localparam logic [TOTALW-1:0] TOTAL_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTRW-1:0]   head_q, head_d;
  logic [PTRW-1:0]   tail_q, tail_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [TOTALW-1:0] total_q, total_d;
  logic              overflow_q, overflow_d;
  logic              done_q;

  logic popEn;
  logic isFull;
  logic pushReq;
  logic pushEn;
  logic overwrite;
  logic fullHit;

  assign popEn   = (count_q != '0) && out_ready;
  assign isFull  = (count_q == FULL_CNT);
  assign pushReq = in_valid && (state_q == ST_RUN);
  assign fullHit = pushReq && isFull && !popEn;

`ifdef OUT_CHANNEL_WRAP_EN
  // A push into a full FIFO replaces the oldest word, like the core's outMemPos wrap.
  assign pushEn    = pushReq;
  assign overwrite = fullHit;
`else
  assign pushEn    = pushReq && (!isFull || popEn);
  assign overwrite = 1'b0;
`endif

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    total_d    = total_q;
    overflow_d = overflow_q | fullHit;
    if (popEn || overwrite) head_d = head_q + PTRW'(1);
    if (pushEn)             tail_d = tail_q + PTRW'(1);
    // An overwrite moves both pointers, so occupancy stays at DEPTH.
    case ({pushEn && !overwrite, popEn})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    if (pushEn && (total_q != TOTAL_MAX)) total_d = total_q + TOTALW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pushEn) mem_q[tail_q] <= in_data;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
    end
  end

  // Draining keeps popping; done only once the buffer has been seen empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (vm_finished) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (count_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[head_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign total     = total_q;
  assign done      = done_q;

endmodule

// File: tb/tb_out_channel_fifo.sv
// Scoreboard bench for out_channel_fifo: expected words queued at push time,
// a negedge monitor compares every host handshake against the queue.
module tb_out_channel_fifo;

  localparam int WIDTH  = 12;
  localparam int DEPTH  = 4;
  localparam int TOTALW = 16;

  logic              clock;
  logic              reset;
  logic              inValid;
  logic [WIDTH-1:0]  inData;
  logic              vmFinished;
  logic              outValid;
  logic [WIDTH-1:0]  outData;
  logic              outReady;
  logic [2:0]        count;
  logic              overflow;
  logic [TOTALW-1:0] total;
  logic              done;

  int assertCount = 0;
  int failCount   = 0;
  int expQ[$];

  out_channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TOTALW(TOTALW)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(inValid),
    .in_data(inData),
    .vm_finished(vmFinished),
    .out_valid(outValid),
    .out_data(outData),
    .out_ready(outReady),
    .count(count),
    .overflow(overflow),
    .total(total),
    .done(done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor: every handshake seen mid-cycle must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && outValid && outReady) begin
         assertCount++;
         if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL pop_unexpected: got data %0d, expected no output", outData);
         end else begin
            int e;
            e = expQ.pop_front();
            if (int'(outData) != e) begin
               failCount++;
               $display("[TB] FAIL pop_data: got %0d, expected %0d", outData, e);
            end
         end
      end
    end
  end

  // Drive one cycle of inputs, then let the edge happen and settle.
  task automatic applyStimulus(input logic v, input int d, input logic fin, input logic rdy);
    inValid    = v;
    inData     = WIDTH'(d);
    vmFinished = fin;
    outReady   = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_count"},    int'(count), 0);
    checkOutput({tag, "_valid"},    int'(outValid), 0);
    checkOutput({tag, "_data"},     int'(outData), 0);
    checkOutput({tag, "_overflow"}, int'(overflow), 0);
    checkOutput({tag, "_total"},    int'(total), 0);
    checkOutput({tag, "_done"},     int'(done), 0);
  endtask

  initial begin
    int seqA[4];
    int seqB[4];
    reset = 1'b1; inValid = 1'b0; inData = '0; vmFinished = 1'b0; outReady = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    checkCleared("reset");

    // Single word: visible the cycle after the push, then popped.
    expQ.push_back(2);
    applyStimulus(1'b1, 2, 1'b0, 1'b1);
    checkOutput("single_valid", int'(outValid), 1);
    checkOutput("single_data", int'(outData), 2);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("single_count", int'(count), 0);
    checkOutput("single_total", int'(total), 1);

    // Full with simultaneous push and pop: occupancy holds, no overflow.
    for (int i = 1; i <= 4; i++) begin
      expQ.push_back(i);
      applyStimulus(1'b1, i, 1'b0, 1'b0);
    end
    checkOutput("fill_count", int'(count), 4);
    expQ.push_back(9);
    applyStimulus(1'b1, 9, 1'b0, 1'b1);
    checkOutput("pushpop_count", int'(count), 4);
    checkOutput("pushpop_overflow", int'(overflow), 0);
    checkOutput("pushpop_total", int'(total), 6);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("pushpop_drained", int'(count), 0);

    // Full boundary: fifth push meets a full FIFO with ready low.
`ifdef OUT_CHANNEL_WRAP_EN
    seqA = '{2, 3, 4, 5};
`else
    seqA = '{1, 2, 3, 4};
`endif
    foreach (seqA[i]) expQ.push_back(seqA[i]);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
    checkOutput("full_count", int'(count), 4);
    checkOutput("full_overflow", int'(overflow), 1);
    checkOutput("full_head", int'(outData), seqA[0]);
`ifdef OUT_CHANNEL_WRAP_EN
    checkOutput("full_total", int'(total), 11);
`else
    checkOutput("full_total", int'(total), 10);
`endif
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("full_overflow_sticky", int'(overflow), 1);

    // Reset mid-stream throws away buffered words (none are queued as expected).
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 100 + i, 1'b0, 1'b0);
    checkOutput("midreset_pre_count", int'(count), 3);
    doReset();
    checkCleared("midreset");

    // Finish and drain, including a push in the finishing cycle.
    seqB = '{10, 20, 30, 40};
    foreach (seqB[i]) expQ.push_back(seqB[i]);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, seqB[i], 1'b0, 1'b0);
    applyStimulus(1'b1, 40, 1'b1, 1'b0);
    checkOutput("finish_count", int'(count), 4);
    applyStimulus(1'b1, 77, 1'b0, 1'b1);
    checkOutput("drain_ignore_count", int'(count), 3);
    checkOutput("drain_ignore_total", int'(total), 4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("drain_empty_count", int'(count), 0);
    checkOutput("drain_done_early", int'(done), 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("drain_done", int'(done), 1);
    applyStimulus(1'b1, 55, 1'b1, 1'b1);
    checkOutput("done_ignore_valid", int'(outValid), 0);
    checkOutput("done_ignore_total", int'(total), 4);
    checkOutput("done_sticky", int'(done), 1);

    // Immediate finish on an empty FIFO: done two cycles later.
    doReset();
    checkOutput("imm_reset_done", int'(done), 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    checkOutput("imm_done_n1", int'(done), 0);
    checkOutput("imm_valid_n1", int'(outValid), 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("imm_done_n2", int'(done), 1);
    checkOutput("imm_valid_n2", int'(outValid), 0);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
